// File: rtl/word_rotator_if.sv
// word_rotator_if: control inputs and display outputs of the word rotator.
//   EN, DIR, STEP, LOAD, PAT[7:0] : driven by the master (board/testbench)
//   ROT[1:0], CH3..CH0[1:0], TICK  : driven by the slave (word_rotator)
interface word_rotator_if;
  logic       EN;
  logic       DIR;
  logic       STEP;
  logic       LOAD;
  logic [7:0] PAT;
  logic [1:0] ROT;
  logic [1:0] CH3;
  logic [1:0] CH2;
  logic [1:0] CH1;
  logic [1:0] CH0;
  logic       TICK;

  modport master (
    output EN, DIR, STEP, LOAD, PAT,
    input  ROT, CH3, CH2, CH1, CH0, TICK
  );

  modport slave (
    input  EN, DIR, STEP, LOAD, PAT,
    output ROT, CH3, CH2, CH1, CH0, TICK
  );
endinterface

// File: rtl/word_rotator.sv
// word_rotator: rotates a four-character word across HEX3..HEX0.
//   CLOCK_50  : sole clock, rising edge
//   KEY0      : asynchronous active-low reset
//   bus.EN    : 1 = auto-rotate every TICK_DIV cycles, 0 = hold
//   bus.DIR   : 0 = rotate left (ROT+1), 1 = rotate right (ROT-1)
//   bus.STEP  : manual single step on rising edge while paused
//   bus.LOAD  : load PAT into the pattern register, ROT and prescaler cleared
//   bus.PAT   : P3..P0 char codes (00=d, 01=E, 10=1, 11=blank)
//   bus.ROT   : current rotation
//   bus.CH3..CH0 : registered char codes, CHk = P[(k - ROT) mod 4]
//   bus.TICK  : one-cycle pulse following every step
module word_rotator #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic          CLOCK_50,
  input logic          KEY0,
  word_rotator_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] RESET_PAT = 8'b00_01_10_11;

  typedef enum logic {PAUSE, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    rot_q, rot_d;
  logic [7:0]    pat_q, pat_d;
  logic          step_q;
  logic          live_q;
  logic          tick_q, tick_d;
  logic [1:0]    ch_q [4];
  logic [1:0]    ch_d [4];

  logic          auto_fire;
  logic          man_fire;
  logic          fire;
  logic [1:0]    idx;

  // State register. live_q registers reset deassertion so that a manual
  // step cannot be taken in the first cycle after release; the auto path
  // cannot fire then either because the prescaler restarts from zero.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q <= PAUSE;
      presc_q <= '0;
      rot_q   <= '0;
      pat_q   <= RESET_PAT;
      step_q  <= 1'b0;
      live_q  <= 1'b0;
      tick_q  <= 1'b0;
      ch_q[3] <= RESET_PAT[7:6];
      ch_q[2] <= RESET_PAT[5:4];
      ch_q[1] <= RESET_PAT[3:2];
      ch_q[0] <= RESET_PAT[1:0];
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rot_q   <= rot_d;
      pat_q   <= pat_d;
      step_q  <= bus.STEP;
      live_q  <= 1'b1;
      tick_q  <= tick_d;
      for (int unsigned k = 0; k < 4; k++) begin
        ch_q[k] <= ch_d[k];
      end
    end
  end

  always_comb begin
    state_d   = bus.EN ? RUN : PAUSE;
    presc_d   = '0;
    rot_d     = rot_q;
    pat_d     = pat_q;
    auto_fire = 1'b0;
    man_fire  = 1'b0;
    idx       = '0;

    // Prescaler: runs only while staying in RUN; any mode change clears it.
    if (state_d == state_q && state_q == RUN) begin
      if (presc_q == LAST) begin
        auto_fire = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    man_fire = (state_q == PAUSE) && bus.STEP && !step_q && live_q;
    fire     = auto_fire || man_fire;

    if (fire) begin
      rot_d = bus.DIR ? rot_q - 2'd1 : rot_q + 2'd1;
    end

    // LOAD wins over any step taken on the same edge.
    if (bus.LOAD) begin
      pat_d   = bus.PAT;
      rot_d   = '0;
      presc_d = '0;
      fire    = 1'b0;
    end

    tick_d = fire;

    // Characters are computed from the next ROT/pattern so the registered
    // outputs stay coherent with ROT in the same cycle.
    for (int unsigned k = 0; k < 4; k++) begin
      idx     = 2'(k) - rot_d;
      ch_d[k] = pat_d[{idx, 1'b0} +: 2];
    end
  end

  assign bus.ROT  = rot_q;
  assign bus.TICK = tick_q;
  assign bus.CH3  = ch_q[3];
  assign bus.CH2  = ch_q[2];
  assign bus.CH1  = ch_q[1];
  assign bus.CH0  = ch_q[0];

endmodule

// File: doc/word_rotator.md
WORD_ROTATOR -- requirements
Module: word_rotator

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, meaning CLOCK_50 cycles per automatic rotation step (legal range >= 2).
REQ-002 CLOCK_50  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 KEY0  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-004 EN  input  1  1 = auto-rotate (RUN), 0 = hold (PAUSE).
REQ-005 DIR  input  1  0 = rotate left (ROT increments), 1 = rotate right (ROT decrements).
REQ-006 STEP  input  1  manual advance; acts on its rising edge, honoured in PAUSE only.
REQ-007 LOAD  input  1  synchronous load of PAT into the pattern register.
REQ-008 PAT  input  8  four 2-bit char codes, P3=PAT[7:6], P2=PAT[5:4], P1=PAT[3:2], P0=PAT[1:0].
REQ-009 ROT  output  2  current rotation select, downstream mux select.
REQ-010 CH3, CH2, CH1, CH0  output  2 each  char codes for HEX3..HEX0 (00=d, 01=E, 10=1, 11=blank).
REQ-011 TICK  output  1  one-cycle pulse in the cycle after ROT changes by a step.

Function
REQ-012 Two states SHALL exist: PAUSE and RUN; next state = RUN when EN=1, PAUSE when EN=0, evaluated every cycle.
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 only while in RUN; in PAUSE it SHALL hold at 0.
REQ-014 On any PAUSE<->RUN transition the prescaler SHALL clear to 0.
REQ-015 In RUN, when prescaler = TICK_DIV-1, it SHALL wrap to 0 and ROT SHALL advance one step on the same edge.
REQ-016 Step arithmetic SHALL be modulo 4: DIR=0 -> ROT+1 (3 wraps to 0); DIR=1 -> ROT-1 (0 wraps to 3).
REQ-017 STEP SHALL be registered once; a rising edge is STEP=1 with previous sample 0; it SHALL advance ROT by one step per edge in PAUSE and be ignored in RUN.
REQ-018 Holding STEP high SHALL produce exactly one advance.
REQ-019 LOAD=1 SHALL set pattern <= PAT, ROT <= 0, prescaler <= 0, and SHALL override any step in the same cycle (no TICK).
REQ-020 CHk SHALL equal pattern slot P[(k - ROT) mod 4], all registered, coherent with ROT (ROT=1: CH3=P2, CH2=P1, CH1=P0, CH0=P3).
REQ-021 TICK SHALL be 1 for exactly one cycle after each step (auto or manual), else 0.
REQ-022 DIR change SHALL take effect at the next step only; no immediate ROT change.
REQ-023 Outputs SHALL be glitch-free registers; no combinational path from inputs to outputs.

Reset
REQ-024 KEY0=0 SHALL immediately force: state PAUSE, prescaler 0, ROT=00, pattern=8'b00_01_10_11, STEP history 0, TICK=0, so CH3..CH0 = 00,01,10,11 ("dE1 ").
REQ-025 Reset mid-count SHALL discard the partial prescaler count; first auto step after release SHALL occur TICK_DIV cycles after RUN is entered.
REQ-026 Deassertion SHALL be registered before use; no step or TICK in the first cycle after release.

Verification (TICK_DIV=4)
REQ-027 Reset, EN=1, DIR=0 -> ROT 0,1,2,3,0 every 4 cycles, TICK one-cycle pulses; CH3..CH0 at ROT=1 = 01,10,11,00.
REQ-028 EN=1, DIR=1 from ROT=0 -> ROT 3,2,1 at 4-cycle intervals.
REQ-029 EN=0, STEP held high 10 cycles -> single ROT 0->1, single TICK; STEP pulse in RUN -> no extra step.
REQ-030 LOAD with PAT=8'hE4 in the same cycle the prescaler hits 3 -> ROT=0, CH3..CH0 = 11,10,01,00, no TICK, next step 4 cycles later.
REQ-031 KEY0 low at prescaler=2, ROT=2 -> ROT=0, CH="dE1 " immediately; after release with EN=1, first TICK after exactly 4 cycles.
REQ-032 EN toggled 1->0->1 at prescaler=2 -> prescaler restarts at 0; next step 4 cycles after re-entering RUN.
